// File: rtl/e1b_code_loader_pkg.sv
// Constants shared by the E1B code loader and the code memory so both agree on width and depth.
// The loader's optional checksum output is enabled with the E1B_LOADER_CHECKSUM_EN define.
package e1b_code_loader_pkg;

  localparam int unsigned E1B_CODEBITS = 12;
  localparam int unsigned E1B_N_WORDS  = 4096;
  localparam int unsigned E1B_ACC_W    = 28;
  localparam int unsigned E1B_CNT_W    = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } loader_state_e;

  // A full code word is buffered once the bit count reaches the code width.
  function automatic logic e1b_can_emit(input logic [E1B_CNT_W-1:0] cnt);
    return cnt >= E1B_CNT_W'(E1B_CODEBITS);
  endfunction

endpackage

// File: rtl/e1b_code_loader_if.sv
// Host-word input handshake plus code-memory write port of the E1B code loader.
interface e1b_code_loader_if
  import e1b_code_loader_pkg::*;
#(
  parameter int unsigned IN_W = 16
);

  logic                    in_valid;
  logic [IN_W-1:0]         in_data;
  logic                    in_ready;
  logic                    wr;
  logic [E1B_CODEBITS-1:0] tos;

  // Host / memory side.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  wr,
    input  tos
  );

  // Loader side.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output wr,
    output tos
  );

endinterface

// File: rtl/e1b_code_loader.sv
// Unpacks 16-bit host words (LSB first) into 12-bit code words and writes N_WORDS of them.
// Define E1B_LOADER_CHECKSUM_EN to add the csum output (XOR of all words written this load).
module e1b_code_loader
  import e1b_code_loader_pkg::*;
#(
  parameter int unsigned N_WORDS = E1B_N_WORDS,
  parameter int unsigned IN_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  e1b_code_loader_if.slave         bus,
  output logic [$clog2(N_WORDS):0] nwords,
  output logic                     busy,
  output logic                     done
`ifdef E1B_LOADER_CHECKSUM_EN
  ,
  output logic [E1B_CODEBITS-1:0]  csum
`endif
);

  localparam int unsigned NwW = $clog2(N_WORDS) + 1;
  localparam logic [NwW-1:0] LastIdx = NwW'(N_WORDS - 1);

  loader_state_e state_q, state_d;

  logic [E1B_ACC_W-1:0]    acc_q, acc_d, acc_s;
  logic [E1B_CNT_W-1:0]    cnt_q, cnt_d, cnt_s;
  logic [NwW-1:0]          nwords_q, nwords_d;
  logic                    wr_q, wr_d;
  logic [E1B_CODEBITS-1:0] tos_q, tos_d;
  logic                    emit, xfer;

`ifdef E1B_LOADER_CHECKSUM_EN
  logic [E1B_CODEBITS-1:0] csum_q, csum_d;
`endif

  assign emit         = (state_q == StLoad) && e1b_can_emit(cnt_q);
  assign bus.in_ready = (state_q == StLoad) && !e1b_can_emit(cnt_q);
  assign xfer         = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    nwords_d = nwords_q;
    wr_d     = 1'b0;
    tos_d    = tos_q;
`ifdef E1B_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif

    // Shift out an emitted word before any append so new bits land at the post-shift count.
    acc_s = emit ? (acc_q >> E1B_CODEBITS) : acc_q;
    cnt_s = emit ? (cnt_q - E1B_CNT_W'(E1B_CODEBITS)) : cnt_q;

    if (start) begin
      state_d  = StLoad;
      acc_d    = '0;
      cnt_d    = '0;
      nwords_d = '0;
`ifdef E1B_LOADER_CHECKSUM_EN
      csum_d   = '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
        end
        StLoad: begin
          acc_d = acc_s;
          cnt_d = cnt_s;
          if (emit) begin
            wr_d     = 1'b1;
            tos_d    = acc_q[E1B_CODEBITS-1:0];
            nwords_d = nwords_q + NwW'(1);
`ifdef E1B_LOADER_CHECKSUM_EN
            csum_d   = csum_q ^ acc_q[E1B_CODEBITS-1:0];
`endif
            if (nwords_q == LastIdx) begin
              state_d = StDone;
            end
          end
          if (xfer) begin
            acc_d = acc_s | (E1B_ACC_W'(bus.in_data[IN_W-1:0]) << cnt_s);
            cnt_d = cnt_s + E1B_CNT_W'(IN_W);
          end
        end
        StDone: begin
          acc_d = '0;
          cnt_d = '0;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      cnt_q    <= '0;
      nwords_q <= '0;
      wr_q     <= 1'b0;
      tos_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      nwords_q <= nwords_d;
      wr_q     <= wr_d;
      tos_q    <= tos_d;
    end
  end

`ifdef E1B_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;
`else
  // No checksum state in the default build.
`endif

  assign bus.wr  = wr_q;
  assign bus.tos = tos_q;
  assign nwords  = nwords_q;
  assign busy    = (state_q == StLoad);
  assign done    = (state_q == StDone);

endmodule

// File: tb/tb_e1b_code_loader.sv
// Directed bench for e1b_code_loader with N_WORDS=8; every write seen on the bus is logged.
module tb_e1b_code_loader;

  localparam int unsigned NWords = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] nwords;
  logic       busy;
  logic       done;
`ifdef E1B_LOADER_CHECKSUM_EN
  logic [11:0] csum;
`endif

  int n_pass   = 0;
  int n_checks = 0;

  logic [11:0] got[$];

  e1b_code_loader_if bus ();

  e1b_code_loader #(
    .N_WORDS(NWords),
    .IN_W   (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .nwords(nwords),
    .busy  (busy),
    .done  (done)
`ifdef E1B_LOADER_CHECKSUM_EN
    ,
    .csum  (csum)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wr === 1'b1) got.push_back(bus.tos);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one word and hold it until the loader takes it (bounded wait).
  task automatic send(input logic [15:0] d);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("send_timeout", 32'(n), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_four(input string tag, input int base,
                            input logic [11:0] e0, input logic [11:0] e1,
                            input logic [11:0] e2, input logic [11:0] e3);
    logic [11:0] e[4];
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < 4; k++) begin
      if (got.size() > base + k) check($sformatf("%s[%0d]", tag, base + k), 32'(got[base + k]), 32'(e[k]));
      else check($sformatf("%s[%0d]_missing", tag, base + k), 32'(got.size()), 32'(base + k + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_wr", 32'(bus.wr), 32'd0);
    check("rst_tos", 32'(bus.tos), 32'd0);
    check("rst_nwords", 32'(nwords), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_wr", 32'(got.size()), 32'd0);

    // Basic packing of one triple
    pulse_start();
    check("a_busy", 32'(busy), 32'd1);
    check("a_in_ready", 32'(bus.in_ready), 32'd1);
    check("a_nwords0", 32'(nwords), 32'd0);
    got.delete();
    send(16'h3210);
    send(16'h7654);
    send(16'hBA98);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("a_count", 32'(got.size()), 32'd4);
    check_four("a_tos", 0, 12'h210, 12'h543, 12'h876, 12'hBA9);
    check("a_nwords", 32'(nwords), 32'd4);
    check("a_done", 32'(done), 32'd0);

    // Full load of N_WORDS with valid held high, then extra words ignored
    pulse_start();
    got.delete();
    send(16'h3210);
    send(16'h7654);
    send(16'hBA98);
    send(16'h1111);
    send(16'h2222);
    send(16'h3333);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("b_count", 32'(got.size()), 32'd8);
    check_four("b_tos", 0, 12'h210, 12'h543, 12'h876, 12'hBA9);
    check_four("b_tos", 4, 12'h111, 12'h221, 12'h322, 12'h333);
    check("b_done", 32'(done), 32'd1);
    check("b_busy", 32'(busy), 32'd0);
    check("b_nwords", 32'(nwords), 32'd8);
    check("b_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;
    repeat (5) @(negedge clk);
    bus.in_valid = 1'b0;
    check("b_extra_ignored", 32'(got.size()), 32'd8);
    check("b_in_ready_held", 32'(bus.in_ready), 32'd0);
    check("b_nwords_held", 32'(nwords), 32'd8);

    // Same stream with irregular valid gaps
    pulse_start();
    got.delete();
    repeat ($urandom_range(0, 3)) begin bus.in_valid = 1'b0; @(negedge clk); end
    send(16'h3210);
    repeat ($urandom_range(0, 3)) begin bus.in_valid = 1'b0; @(negedge clk); end
    send(16'h7654);
    repeat ($urandom_range(0, 3)) begin bus.in_valid = 1'b0; @(negedge clk); end
    send(16'hBA98);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("c_count", 32'(got.size()), 32'd4);
    check_four("c_tos", 0, 12'h210, 12'h543, 12'h876, 12'hBA9);

    // Restart after a partial load
    pulse_start();
    got.delete();
    send(16'hAAAA);
    send(16'h5555);
    send(16'h0F0F);
    send(16'hF0F0);
    send(16'h1234);
    bus.in_valid = 1'b0;
    pulse_start();
    check("d_nwords0", 32'(nwords), 32'd0);
    check("d_no_wr", 32'(bus.wr), 32'd0);
    check("d_busy", 32'(busy), 32'd1);
    got.delete();
    send(16'h3210);
    send(16'h7654);
    send(16'hBA98);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("d_count", 32'(got.size()), 32'd4);
    check_four("d_tos", 0, 12'h210, 12'h543, 12'h876, 12'hBA9);

    // Reset in the middle of a load
    pulse_start();
    send(16'h3210);
    send(16'h7654);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("e_wr", 32'(bus.wr), 32'd0);
    check("e_tos", 32'(bus.tos), 32'd0);
    check("e_nwords", 32'(nwords), 32'd0);
    check("e_busy", 32'(busy), 32'd0);
    check("e_done", 32'(done), 32'd0);
    check("e_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    got.delete();
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h3210;
    repeat (5) @(negedge clk);
    bus.in_valid = 1'b0;
    check("e_no_wr_after_rst", 32'(got.size()), 32'd0);
    check("e_in_ready_idle", 32'(bus.in_ready), 32'd0);
    pulse_start();
    send(16'h3210);
    send(16'h7654);
    send(16'hBA98);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("e_count", 32'(got.size()), 32'd4);
    check_four("e_tos", 0, 12'h210, 12'h543, 12'h876, 12'hBA9);

`ifdef E1B_LOADER_CHECKSUM_EN
    // Checksum over a full load padded with zero words
    pulse_start();
    check("f_csum_clr", 32'(csum), 32'd0);
    send(16'h3210);
    send(16'h7654);
    send(16'hBA98);
    send(16'h0000);
    send(16'h0000);
    send(16'h0000);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("f_done", 32'(done), 32'd1);
    check("f_csum", 32'(csum), 32'h48C);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
